serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised bit-serial adder/subtractor. Accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single full-adder slice with a registered carry. Produces the sum, carry-out and signed-overflow flag, plus a one-cycle done pulse. Sits in the arithmetic library as the area-minimal alternative to the parallel ripple adder for datapaths that can tolerate WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only when not busy
- sub  in  1  0 = a+b+cin, 1 = a-b (cin ignored)
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- cin  in  1  carry-in for add, sampled with start
- busy  out  1  high while RUN
- done  out  1  one-cycle pulse, result valid
- sum  out  WIDTH  result, registered
- cout  out  1  final carry; in sub mode 1 = no borrow
- ovf  out  1  signed overflow (two's complement)

## Operation
- Single clock clk; reset rst_n asynchronous, active-low.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, load shift regs A <= a, B <= sub ? ~b : b, carry <= sub ? 1 : cin, bit counter <= 0; go RUN.
- RUN: each cycle full-adder slice takes A[0], B[0], carry; sum bit shifted into MSB of result shift reg; A, B shift right; carry <= slice cout; counter increments. Carry into MSB slice captured for ovf.
- After bit WIDTH-1 processed: sum <= result reg, cout <= final carry, ovf <= carry-into-MSB XOR final carry; go DONE.
- DONE: done=1 for exactly this cycle; start here is accepted exactly as in IDLE (back-to-back); otherwise go IDLE.
- start while RUN: ignored, no effect on in-flight op.
- sum/cout/ovf hold previous result through RUN; change only on completion edge.
- WIDTH=1: carry-into-MSB is the initial carry.
- Operands, sub and cin need only be valid in the start-sampling cycle.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, internal regs 0.
- Reset mid-RUN: immediate abort, all outputs to reset values, no done pulse; next start runs normally.
- start sampled at edge E0 -> busy high after E0; bits processed at E1..E_WIDTH; result registered and done high after E_WIDTH, busy low in that same cycle; done low after E_WIDTH+1.
- Latency start-edge to done: WIDTH cycles; max throughput one op per WIDTH+1 cycles.
- busy and done never high together.

## Structure
- Package serial_addsub_pkg: state encoding constants/typedef (IDLE, RUN, DONE), counter width function clog2(WIDTH+1).
- One sub-module instance: the team's existing fulladder cell as the bit slice; all sequencing, shift registers and flags in serial_addsub.
- No other hierarchy.

## Test plan
- WIDTH=8, add a=8'h3C, b=8'h05, cin=0 -> done pulse exactly 8 cycles after start edge; sum=8'h41, cout=0, ovf=0.
- Add a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; same with cin=1 -> sum=8'h01, cout=1.
- Add a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Sub a=8'h10, b=8'h20 -> sum=8'hF0, cout=0, ovf=0; sub a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- start pulsed during RUN cycle 3 ignored (sum unchanged, single done); rst_n low during RUN cycle 4 -> busy=0, done=0, sum=0 asynchronously, no done; following start completes correctly.
- start held high continuously -> done pulses every 9 cycles, busy low only in done cycles, each result correct for operands presented at its start edge.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding and the bit-counter width helper.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest number of bits able to index 'value' distinct states.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_fulladder.sv
// Single-bit full adder cell used as the serial arithmetic slice.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  logic w_p;

  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first, WIDTH cycles
// per operation, with carry-out, signed overflow and a one-cycle done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CNT_W = clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic             w_load;

  fulladder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_co)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_load = i_start && (r_state != ST_RUN);
  assign o_busy = (r_state == ST_RUN);
  assign o_done = (r_state == ST_DONE);

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_s;
    end else begin : g_res_wn
      assign w_res_next = {w_s, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last)  w_state_next = ST_DONE;
      ST_DONE: w_state_next = i_start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // On the last slice r_carry is the carry into the MSB, so overflow is
  // available without a separate capture register (also covers WIDTH=1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub ? 1'b1 : i_cin;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_next;
      r_carry <= w_co;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        o_sum  <= w_res_next;
        o_cout <= w_co;
        o_ovf  <= r_carry ^ w_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed and random ops
// compared against an integer-arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         i_start;
  logic         i_sub;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] prev_sum = '0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_sub   (i_sub),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic c,
                                output logic [W-1:0] es, output logic ec, output logic eo);
    int u;
    int r;
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (!s) begin
      u = int'(a) + int'(b) + int'(c);
      r = sa + sb + int'(c);
    end else begin
      u = int'(a) - int'(b) + 256;
      r = sa - sb;
    end
    es = u[W-1:0];
    ec = (u >= 256);
    eo = (r < -128) || (r > 127);
  endfunction

  task automatic scramble();
    i_a   = W'($urandom);
    i_b   = W'($urandom);
    i_sub = 1'($urandom);
    i_cin = 1'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input bit inject);
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           n;
    model(a, b, s, c, es, ec, eo);
    @(negedge clk);
    i_a = a; i_b = b; i_sub = s; i_cin = c; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    scramble();
    check("busy_after_start", o_busy, 1);
    check("sum_hold", o_sum, prev_sum);
    n = 0;
    while (!o_done && n < 20) begin
      if (inject && n == 3) i_start = 1'b1;
      @(posedge clk); #1;
      n++;
      i_start = 1'b0;
      check("busy_done_excl", o_busy & o_done, 0);
    end
    $display("op a=%02h b=%02h sub=%0d cin=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d (exp %02h %0d %0d)",
             a, b, s, c, o_sum, o_cout, o_ovf, n, es, ec, eo);
    check("latency", n, 8);
    check("sum", o_sum, es);
    check("cout", o_cout, ec);
    check("ovf", o_ovf, eo);
    check("busy_in_done", o_busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", o_done, 0);
    check("idle_after_done", o_busy, 0);
    prev_sum = es;
  endtask

  task automatic back_to_back(input int n_ops);
    logic [W-1:0] op_a [8];
    logic [W-1:0] op_b [8];
    logic         op_s [8];
    logic         op_c [8];
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           n;
    for (int k = 0; k < n_ops; k++) begin
      op_a[k] = W'($urandom); op_b[k] = W'($urandom);
      op_s[k] = 1'($urandom); op_c[k] = 1'($urandom);
    end
    @(negedge clk);
    i_a = op_a[0]; i_b = op_b[0]; i_sub = op_s[0]; i_cin = op_c[0]; i_start = 1'b1;
    @(posedge clk); #1;
    i_a = op_a[1]; i_b = op_b[1]; i_sub = op_s[1]; i_cin = op_c[1];
    for (int k = 0; k < n_ops; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
        if (n == 1 && k == n_ops - 1) i_start = 1'b0;
        else if (n == 1 && k > 0) begin
          i_a = op_a[k+1]; i_b = op_b[k+1]; i_sub = op_s[k+1]; i_cin = op_c[k+1];
        end
        if (!o_done) check("b2b_busy", o_busy, 1);
      end while (!o_done && n < 20);
      model(op_a[k], op_b[k], op_s[k], op_c[k], es, ec, eo);
      $display("b2b %0d a=%02h b=%02h sub=%0d cin=%0d -> sum=%02h cout=%0d ovf=%0d gap=%0d (exp %02h %0d %0d)",
               k, op_a[k], op_b[k], op_s[k], op_c[k], o_sum, o_cout, o_ovf, n, es, ec, eo);
      check("b2b_gap", n, (k == 0) ? 8 : 9);
      check("b2b_busy_low", o_busy, 0);
      check("b2b_sum", o_sum, es);
      check("b2b_cout", o_cout, ec);
      check("b2b_ovf", o_ovf, eo);
      prev_sum = es;
    end
    @(posedge clk); #1;
    check("b2b_end_done", o_done, 0);
    check("b2b_end_busy", o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0; i_sub = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_sum", o_sum, 0);
    check("rst_cout", o_cout, 0);
    check("rst_ovf", o_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h3C, 8'h05, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    run_op(8'h5A, 8'h33, 1'b0, 1'b1, 1'b1);

    // Abort an operation with reset in the middle of RUN.
    @(negedge clk);
    i_a = 8'h12; i_b = 8'h34; i_sub = 1'b0; i_cin = 1'b0; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("reset mid-run: busy=%0d done=%0d sum=%02h cout=%0d ovf=%0d",
             o_busy, o_done, o_sum, o_cout, o_ovf);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_sum", o_sum, 0);
    check("abort_cout", o_cout, 0);
    check("abort_ovf", o_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = '0;
    repeat (10) begin
      @(posedge clk); #1;
      check("abort_no_done", o_done, 0);
    end
    run_op(8'hC8, 8'h64, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    back_to_back(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
